frame_buf_ring: RTL
===================

# frame_buf_ring

Single-clock, N-deep frame ring buffer: the parametrised successor to the single-buffer frame store. A producer writes whole frames of `2**ADDR_WIDTH` words into a ring of `NUM_BUFS` frame slots, and a consumer drains complete frames in FIFO order. Producer and consumer may overlap freely, provided they use different slots. The block sits between the pixel source and the display/readout path, and it replaces single-buffer tearing with whole-frame handoff and flow control.

## Interface
- `DATA_WIDTH`, 24: word width.
- `ADDR_WIDTH`, 3: word address bits per frame. Frame length is `FRAME_WORDS = 2**ADDR_WIDTH`.
- `NUM_BUFS`, 2: number of frame slots. Legal range is 1..16; any value, not only powers of two.
- `clk`  in  1  the single clock. All logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `wr_en_in`  in  1  write strobe, active-high, one word per cycle.
- `data_in`  in  DATA_WIDTH  write data.
- `wr_rdy`  out  1  a word is accepted this cycle if `wr_en_in` is high.
- `rd_en_in`  in  1  read strobe, active-high, one word per cycle.
- `rd_rdy`  out  1  a read is accepted this cycle if `rd_en_in` is high.
- `data_out`  out  DATA_WIDTH  registered read data.
- `rd_valid`  out  1  `data_out` holds the word accepted on the previous cycle.
- `frame_cnt`  out  `$clog2(NUM_BUFS+1)`  number of complete, not-yet-fully-read frames.
- `drop_cnt`  out  16  count of dropped write words (see Configuration).
- `underrun`  out  1  sticky flag for a read attempted while empty (see Configuration).

## Operation
**Storage**
- One dual-port memory of `NUM_BUFS*FRAME_WORDS` words.
- Physical address is `slot*FRAME_WORDS + word`.

**Write FSM: IDLE / FILL**
- `wr_rdy = !reset && (state==FILL || frame_cnt < NUM_BUFS)`.
- IDLE, on an accepted word: write word 0 to slot `wr_slot`; set `wr_addr=1`; go to FILL.
- FILL, on an accepted word: write to `{wr_slot, wr_addr}` and increment `wr_addr`.
- On the word at address `FRAME_WORDS-1`: `wr_slot` advances (wrapping `NUM_BUFS-1`→0), `frame_cnt` increments, and the FSM returns to IDLE.
- FILL with `wr_en_in` low: hold; no timeout.

**Read FSM: IDLE / READ**
- `rd_rdy = !reset && (state==READ || frame_cnt > 0)`.
- Accepted reads walk `{rd_slot, rd_addr}` from 0 to `FRAME_WORDS-1`.
- On the last word: `rd_slot` advances (wrapping), `frame_cnt` decrements, and the FSM returns to IDLE.
- A slot being read still counts in `frame_cnt` until its last word is accepted. The slot being filled never counts. Hence the write and read slots never coincide.

**Simultaneous events**
- Write-frame completion and read-frame completion in the same cycle: `frame_cnt` is unchanged.
- Write completes while `frame_cnt==0`: `rd_rdy` rises the next cycle, never the same cycle.
- `frame_cnt==NUM_BUFS` (full), writer in IDLE: `wr_rdy`=0 and offered words are dropped. A read completion frees a slot, and `wr_rdy` rises the next cycle.
- `NUM_BUFS=1`: the block degenerates to strict alternation, fill then drain.

**Reset, at any time including mid-frame**
- Both FSMs go to IDLE; `wr_slot`, `rd_slot`, `wr_addr`, `rd_addr` and `frame_cnt` go to 0.
- `rd_valid`=0 and `data_out`=0.
- `wr_rdy`=`rd_rdy`=0 while reset is high; the frame in flight is discarded.
- Memory contents are not cleared.

## Timing
- Read latency is 1: read accepted at cycle t gives `data_out` and `rd_valid`=1 at t+1.
- Write-to-read latency is 1: last write word at cycle t gives `frame_cnt` and `rd_rdy` updated at t+1. The first read may be accepted at t+1, and its data appears at t+2.
- `rd_valid` is low on any cycle after a non-accepted read. `data_out` holds its last value.
- Sustained throughput is 1 word/cycle on each side, provided neither side is blocked.

## Configuration
`FRAME_BUF_STATS_EN`

**Defined:**
- `drop_cnt` increments, saturating at 0xFFFF, on every cycle with `wr_en_in && !wr_rdy`.
- `underrun` sets on `rd_en_in && !rd_rdy` with reset low.
- Both clear only on reset.

**Undefined:**
- Both ports remain present but are tied to 0.
- No counter logic is synthesised.

## Structure
- Shared package `frame_buf_pkg`:
  - write-FSM state encodings `WR_IDLE`, `WR_FILL`;
  - read-FSM state encodings `RD_IDLE`, `RD_READ`;
  - `DROP_CNT_W`=16;
  - a slot-index width function `$clog2` with a floor of 1.
- Sub-module `fb_ring_mem`: a simple dual-port RAM with one write port, one registered read port and a single clock. The top level holds both FSMs, the pointers and `frame_cnt`.

## Test plan
- **Basic handoff.** Defaults; after reset write 8 words 0x000001..0x000008, then read 8 → `rd_rdy` rises the cycle after word 8. `data_out` shows 0x000001..0x000008 with `rd_valid` delayed one cycle each. `frame_cnt` goes 0→1→0.
- **Full and drop.** `NUM_BUFS`=2; write 3 frames with no reads. Words 17+ are dropped and `wr_rdy`=0 from cycle 16; with the macro defined, `drop_cnt`=8. Read one frame → `wr_rdy` is 1 the cycle after the 8th read.
- **Overlap.** `NUM_BUFS`=3; stream writes continuously and start reading frame 0 once `frame_cnt`=1 → no drops. Read data equals write data in order across the slot wrap 2→0.
- **Simultaneous completion.** Align the last write word of frame k+1 with the last read word of frame k → `frame_cnt` is unchanged that cycle.
- **Reset mid-frame.** Assert reset after 5 words of frame 0 and 3 reads of a previous frame → the next cycle shows `frame_cnt`=0, `rd_valid`=0, `data_out`=0. A fresh frame of 8 words then reads back exactly.
- **Underrun.** Assert `rd_en_in` while empty → no `rd_valid`. `underrun`=1 with the macro defined, 0 without.

Source files
------------

// File: rtl/frame_buf_pkg.sv
// frame_buf_pkg: shared definitions for the frame ring buffer.
//   wr_state_t / rd_state_t : write and read FSM state encodings
//   DROP_CNT_W              : width of the dropped-word counter
//   slot_w()                : index width for n entries, never below 1 bit
package frame_buf_pkg;

   typedef enum logic {WR_IDLE = 1'b0, WR_FILL = 1'b1} wr_state_t;
   typedef enum logic {RD_IDLE = 1'b0, RD_READ = 1'b1} rd_state_t;

   localparam int DROP_CNT_W = 16;

   function automatic int slot_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/fb_ring_mem.sv
// fb_ring_mem: simple dual-port RAM, one write port and one registered read
// port on a single clock. The read register clears on reset and holds its
// value on cycles without a read.
//   clk, reset              : clock, synchronous active-high reset (read reg only)
//   wr_en, wr_addr, wr_data : write port
//   rd_en, rd_addr, rd_data : read port, data one cycle after rd_en
module fb_ring_mem #(
   parameter int DATA_WIDTH = 24,
   parameter int DEPTH      = 16,
   parameter int AW         = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wr_en,
   input  logic [AW-1:0]         wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   input  logic [AW-1:0]         rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // Contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (reset)      rd_data <= '0;
      else if (rd_en) rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/frame_buf_ring.sv
// frame_buf_ring: N-deep frame ring buffer. A producer fills whole frames of
// 2**ADDR_WIDTH words into NUM_BUFS slots; a consumer drains complete frames
// in FIFO order. Writer and reader always work on different slots because the
// slot being filled is never counted in frame_cnt.
//   clk, reset            : clock, synchronous active-high reset
//   wr_en_in, data_in     : write strobe / data, accepted when wr_rdy
//   wr_rdy                : write side ready
//   rd_en_in, rd_rdy      : read strobe, accepted when rd_rdy
//   data_out, rd_valid    : registered read data, valid one cycle after accept
//   frame_cnt             : complete frames not yet fully read
//   drop_cnt, underrun    : statistics, live only with FRAME_BUF_STATS_EN
//                           defined, otherwise tied to 0
module frame_buf_ring
   import frame_buf_pkg::*;
#(
   parameter int DATA_WIDTH = 24,
   parameter int ADDR_WIDTH = 3,
   parameter int NUM_BUFS   = 2
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          wr_en_in,
   input  logic [DATA_WIDTH-1:0]         data_in,
   output logic                          wr_rdy,
   input  logic                          rd_en_in,
   output logic                          rd_rdy,
   output logic [DATA_WIDTH-1:0]         data_out,
   output logic                          rd_valid,
   output logic [$clog2(NUM_BUFS+1)-1:0] frame_cnt,
   output logic [DROP_CNT_W-1:0]         drop_cnt,
   output logic                          underrun
);

   localparam int FRAME_WORDS = 2**ADDR_WIDTH;
   localparam int SLOT_W      = slot_w(NUM_BUFS);
   localparam int CNT_W       = $clog2(NUM_BUFS+1);
   localparam int MEM_DEPTH   = NUM_BUFS*FRAME_WORDS;
   localparam int MEM_AW      = slot_w(MEM_DEPTH);
   localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_BUFS-1);
   localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(NUM_BUFS);

   wr_state_t             wr_state;
   rd_state_t             rd_state;
   logic [SLOT_W-1:0]     wr_slot, rd_slot;
   logic [ADDR_WIDTH-1:0] wr_addr, rd_addr;
   logic                  wr_acc, rd_acc, wr_last, rd_last;
   logic [MEM_AW-1:0]     wr_paddr, rd_paddr;

   assign wr_rdy  = !reset && (wr_state == WR_FILL || frame_cnt < FULL_CNT);
   assign rd_rdy  = !reset && (rd_state == RD_READ || frame_cnt != '0);
   assign wr_acc  = wr_en_in && wr_rdy;
   assign rd_acc  = rd_en_in && rd_rdy;
   assign wr_last = wr_acc && (wr_addr == '1);
   assign rd_last = rd_acc && (rd_addr == '1);

   // FRAME_WORDS is a power of two, so slot*FRAME_WORDS+word is a concatenation.
   assign wr_paddr = MEM_AW'({wr_slot, wr_addr});
   assign rd_paddr = MEM_AW'({rd_slot, rd_addr});

   // Write FSM: IDLE takes word 0 of a new frame, FILL the rest. The word
   // address wraps to 0 by itself on the last word.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_state <= WR_IDLE;
         wr_slot  <= '0;
         wr_addr  <= '0;
      end else if (wr_acc) begin
         wr_addr <= wr_addr + 1'b1;
         if (wr_last) begin
            wr_state <= WR_IDLE;
            wr_slot  <= (wr_slot == LAST_SLOT) ? '0 : wr_slot + 1'b1;
         end else begin
            wr_state <= WR_FILL;
         end
      end
   end

   // Read FSM mirrors the writer on the drain side.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_state <= RD_IDLE;
         rd_slot  <= '0;
         rd_addr  <= '0;
      end else if (rd_acc) begin
         rd_addr <= rd_addr + 1'b1;
         if (rd_last) begin
            rd_state <= RD_IDLE;
            rd_slot  <= (rd_slot == LAST_SLOT) ? '0 : rd_slot + 1'b1;
         end else begin
            rd_state <= RD_READ;
         end
      end
   end

   // Completion on both sides in one cycle leaves the count unchanged.
   always_ff @(posedge clk) begin
      if (reset)                    frame_cnt <= '0;
      else if (wr_last && !rd_last) frame_cnt <= frame_cnt + 1'b1;
      else if (rd_last && !wr_last) frame_cnt <= frame_cnt - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) rd_valid <= 1'b0;
      else       rd_valid <= rd_acc;
   end

   fb_ring_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (MEM_DEPTH),
      .AW         (MEM_AW)
   ) u_mem (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (wr_acc),
      .wr_addr (wr_paddr),
      .wr_data (data_in),
      .rd_en   (rd_acc),
      .rd_addr (rd_paddr),
      .rd_data (data_out)
   );

`ifdef FRAME_BUF_STATS_EN
   logic [DROP_CNT_W-1:0] drop_q;
   logic                  underrun_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         drop_q     <= '0;
         underrun_q <= 1'b0;
      end else begin
         if (wr_en_in && !wr_rdy && drop_q != '1) drop_q <= drop_q + 1'b1;
         if (rd_en_in && !rd_rdy)                 underrun_q <= 1'b1;
      end
   end

   assign drop_cnt = drop_q;
   assign underrun = underrun_q;
`else
   assign drop_cnt = '0;
   assign underrun = 1'b0;
`endif

endmodule
